// File: rtl/branch_pc_unit_if.sv
// rtl/branch_pc_unit_if.sv - execute-stage branch operands and fetch-PC/redirect results
interface branch_pc_unit_if #(
  parameter int PC_WIDTH = 12
);
  logic                stall;
  logic                ex_valid;
  logic [2:0]          ex_type;
  logic [PC_WIDTH-1:0] ex_pc;
  logic [16:0]         ex_imm;
  logic [26:0]         ex_target;
  logic [31:0]         ex_rd_val;
  logic [31:0]         ex_rs_val;
  logic [PC_WIDTH-1:0] pc;
  logic                flush;
  logic                link_we;
  logic [31:0]         link_data;
  logic [15:0]         taken_cnt;
  logic [15:0]         nottaken_cnt;

  modport master (
    output stall, ex_valid, ex_type, ex_pc, ex_imm, ex_target, ex_rd_val, ex_rs_val,
    input  pc, flush, link_we, link_data, taken_cnt, nottaken_cnt
  );

  modport slave (
    input  stall, ex_valid, ex_type, ex_pc, ex_imm, ex_target, ex_rd_val, ex_rs_val,
    output pc, flush, link_we, link_data, taken_cnt, nottaken_cnt
  );
endinterface

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - fetch PC register with execute-stage branch resolution and redirect
module branch_pc_unit #(
  parameter int PC_WIDTH = 12,
  parameter int RESET_PC = 0
) (
  input logic               clock,
  input logic               reset,
  branch_pc_unit_if.slave   bus
);
  typedef enum logic {RUN, PEND} state_t;

  localparam logic [2:0] T_J   = 3'd1;
  localparam logic [2:0] T_BNE = 3'd2;
  localparam logic [2:0] T_JAL = 3'd3;
  localparam logic [2:0] T_JR  = 3'd4;
  localparam logic [2:0] T_BLT = 3'd5;
  localparam logic [2:0] T_BEX = 3'd6;

  state_t              state;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pend_target;
  logic                counted;
  logic [15:0]         taken_q;
  logic [15:0]         nottaken_q;

  logic                taken;
  logic                cond;
  logic [PC_WIDTH-1:0] tgt;
  logic [31:0]         br_sum;
  logic [PC_WIDTH-1:0] ex_pc_inc;
  logic                count_en;
  logic                unused_bits;

  assign br_sum    = {{(32-PC_WIDTH){1'b0}}, bus.ex_pc} + 32'd1 + {{15{bus.ex_imm[16]}}, bus.ex_imm};
  assign ex_pc_inc = bus.ex_pc + PC_WIDTH'(1);

  // Resolution only matters in RUN; in PEND execute holds a squashed op.
  always_comb begin
    taken = 1'b0;
    cond  = 1'b0;
    tgt   = '0;
    if (bus.ex_valid && state == RUN) begin
      case (bus.ex_type)
        T_J, T_JAL: begin
          taken = 1'b1;
          tgt   = bus.ex_target[PC_WIDTH-1:0];
        end
        T_JR: begin
          taken = 1'b1;
          tgt   = bus.ex_rd_val[PC_WIDTH-1:0];
        end
        T_BNE: begin
          cond  = 1'b1;
          taken = bus.ex_rd_val != bus.ex_rs_val;
          tgt   = br_sum[PC_WIDTH-1:0];
        end
        T_BLT: begin
          cond  = 1'b1;
          taken = $signed(bus.ex_rd_val) < $signed(bus.ex_rs_val);
          tgt   = br_sum[PC_WIDTH-1:0];
        end
        T_BEX: begin
          cond  = 1'b1;
          taken = bus.ex_rs_val != 32'd0;
          tgt   = bus.ex_target[PC_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign count_en = !counted && (taken || cond);

  assign bus.pc           = pc_q;
  assign bus.flush        = !reset && (state == PEND || taken);
  assign bus.link_we      = !reset && bus.ex_valid && bus.ex_type == T_JAL;
  assign bus.link_data    = {{(32-PC_WIDTH){1'b0}}, ex_pc_inc};
  assign bus.taken_cnt    = taken_q;
  assign bus.nottaken_cnt = nottaken_q;

  assign unused_bits = ^{br_sum[31:PC_WIDTH], bus.ex_target[26:PC_WIDTH], bus.ex_rd_val[31:PC_WIDTH]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pc_q        <= PC_WIDTH'(RESET_PC);
      pend_target <= '0;
      counted     <= 1'b0;
      taken_q     <= '0;
      nottaken_q  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (taken) begin
            if (bus.stall) begin
              pend_target <= tgt;
              state       <= PEND;
            end else begin
              pc_q <= tgt;
            end
          end else if (!bus.stall) begin
            pc_q <= pc_q + PC_WIDTH'(1);
          end
        end
        PEND: begin
          if (!bus.stall) begin
            pc_q  <= pend_target;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase

      if (count_en && taken && taken_q != 16'hFFFF)
        taken_q <= taken_q + 16'd1;
      if (count_en && !taken && nottaken_q != 16'hFFFF)
        nottaken_q <= nottaken_q + 16'd1;
      // A stalled op stays in execute; remember it was already counted until stall drops.
      counted <= bus.stall && (counted || count_en);
    end
  end
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - scoreboard bench for branch_pc_unit against a behavioural model
module tb_branch_pc_unit;
  localparam int PW = 12;
  localparam int PC_MOD = 1 << PW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  branch_pc_unit_if #(.PC_WIDTH(PW)) bus ();
  branch_pc_unit #(.PC_WIDTH(PW), .RESET_PC(0)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    string label;
    int    pc;
    bit    flush;
    bit    link_we;
    int    link_data;
    int    tcnt;
    int    ncnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  int m_pc   = 0;
  int m_pend = -1;
  int m_t    = 0;
  int m_n    = 0;
  bit m_held = 1'b0;

  function automatic int wrap(input int v);
    return ((v % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic step(input bit rst, input bit stl, input bit vld, input int typ, input int epc,
                      input int imm, input int tgt27, input logic [31:0] rd, input logic [31:0] rs,
                      input string label);
    exp_t e;
    bit   tk;
    bit   cond;
    bit   counting;
    int   nxt;
    reset         = rst;
    bus.stall     = stl;
    bus.ex_valid  = vld;
    bus.ex_type   = 3'(typ);
    bus.ex_pc     = PW'(epc);
    bus.ex_imm    = 17'(imm);
    bus.ex_target = 27'(tgt27);
    bus.ex_rd_val = rd;
    bus.ex_rs_val = rs;
    tk = 1'b0; cond = 1'b0; nxt = 0;
    if (rst) begin
      m_pc = 0; m_pend = -1; m_t = 0; m_n = 0; m_held = 1'b0;
    end else if (m_pend < 0 && vld) begin
      case (typ)
        1, 3: begin tk = 1'b1; nxt = tgt27 % PC_MOD; end
        4:    begin tk = 1'b1; nxt = int'(rd) & (PC_MOD - 1); end
        2:    begin cond = 1'b1; tk = (rd != rs); nxt = wrap(epc + 1 + imm); end
        5:    begin cond = 1'b1; tk = (int'(rd) < int'(rs)); nxt = wrap(epc + 1 + imm); end
        6:    begin cond = 1'b1; tk = (rs != 0); nxt = tgt27 % PC_MOD; end
        default: ;
      endcase
    end
    e.label     = label;
    e.pc        = m_pc;
    e.flush     = !rst && (m_pend >= 0 || tk);
    e.link_we   = !rst && vld && typ == 3;
    e.link_data = wrap(epc + 1);
    e.tcnt      = m_t;
    e.ncnt      = m_n;
    sb.push_back(e);
    if (!rst) begin
      counting = (m_pend < 0) && !m_held && (tk || cond);
      if (counting && tk) m_t = sat_inc(m_t);
      if (counting && !tk) m_n = sat_inc(m_n);
      m_held = stl && (m_held || counting);
      if (m_pend >= 0) begin
        if (!stl) begin m_pc = m_pend; m_pend = -1; end
      end else if (tk) begin
        if (stl) m_pend = nxt;
        else m_pc = nxt;
      end else if (!stl) begin
        m_pc = wrap(m_pc + 1);
      end
    end
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input string label);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 32'd0, 32'd0, label);
  endtask

  initial begin : monitor
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        ok = (int'(bus.pc) == e.pc) && (bus.flush == e.flush) && (bus.link_we == e.link_we) &&
             (!e.link_we || int'(bus.link_data) == e.link_data) &&
             (int'(bus.taken_cnt) == e.tcnt) && (int'(bus.nottaken_cnt) == e.ncnt);
        if (ok) passed++;
        else $display("FAIL %s: got pc=%0d flush=%0b link_we=%0b link_data=%0d taken=%0d nottaken=%0d, expected pc=%0d flush=%0b link_we=%0b link_data=%0d taken=%0d nottaken=%0d",
                      e.label, bus.pc, bus.flush, bus.link_we, bus.link_data, bus.taken_cnt, bus.nottaken_cnt,
                      e.pc, e.flush, e.link_we, e.link_data, e.tcnt, e.ncnt);
      end
    end
  end

  initial begin : driver
    logic [31:0] rd;
    logic [31:0] rs;
    bus.stall = 1'b0; bus.ex_valid = 1'b0; bus.ex_type = '0; bus.ex_pc = '0;
    bus.ex_imm = '0; bus.ex_target = '0; bus.ex_rd_val = '0; bus.ex_rs_val = '0;
    @(posedge clock);
    #2;
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 32'd0, 32'd0, "reset_state");
    idle("run_inc0");
    idle("run_inc1");

    step(1'b0, 1'b0, 1'b1, 2, 5, 3, 0, 32'd4, 32'd7, "bne_taken");
    idle("bne_target");
    step(1'b0, 1'b0, 1'b1, 2, 9, 3, 0, 32'd42, 32'd42, "bne_not_taken");
    idle("bne_nt_inc");
    step(1'b0, 1'b0, 1'b1, 5, 10, 4, 0, 32'hFFFF_FFFF, 32'd1, "blt_signed_taken");
    idle("blt_target");
    step(1'b0, 1'b0, 1'b1, 5, 12, 4, 0, 32'd76, 32'd76, "blt_equal");
    step(1'b0, 1'b0, 1'b1, 5, 2, -6, 0, 32'hFFFF_FFFB, 32'd3, "blt_wrap");
    idle("blt_wrap_target");
    step(1'b0, 1'b0, 1'b1, 3, 10, 0, 20, 32'd0, 32'd0, "jal_link");
    idle("jal_target");
    step(1'b0, 1'b0, 1'b1, 4, 20, 0, 0, 32'd37, 32'd0, "jr");
    idle("jr_target");
    step(1'b0, 1'b0, 1'b1, 6, 40, 0, 77, 32'd0, 32'd5, "bex_taken");
    idle("bex_target");
    step(1'b0, 1'b0, 1'b1, 6, 78, 0, 90, 32'd0, 32'd0, "bex_not_taken");
    step(1'b0, 1'b0, 1'b0, 1, 79, 0, 99, 32'd0, 32'd0, "bubble_j");
    idle("bubble_after");

    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, 1, 30, 0, 50, 32'd0, 32'd0, "j_stall_held");
    idle("stall_drop");
    idle("stall_target");
    step(1'b0, 1'b1, 1'b1, 3, 60, 0, 300, 32'd0, 32'd0, "jal_stall_link");
    step(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 32'd0, 32'd0, "pend_hold");
    step(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 32'd0, 32'd0, "reset_mid_pend");
    step(1'b1, 1'b0, 1'b1, 1, 0, 0, 123, 32'd0, 32'd0, "reset_held_taken");
    idle("after_reset");

    for (int i = 0; i < 400; i++) begin
      rd = ($urandom_range(0, 1) == 1) ? $urandom() : 32'(int'($urandom_range(0, 4)) - 2);
      rs = ($urandom_range(0, 1) == 1) ? $urandom() : 32'(int'($urandom_range(0, 4)) - 2);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, PC_MOD - 2)),
           int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, (1 << 27) - 1)),
           rd, rs, "random");
    end

    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 32'd0, 32'd0, "sat_reset");
    for (int i = 0; i < 65540; i++)
      step(1'b0, 1'b0, 1'b1, 1, 0, 0, 200 + (i % 7), 32'd0, 32'd0, "taken_saturation");
    idle("sat_hold");

    @(negedge clock);
    #1;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
